// File: rtl/square_move_if.sv
// Move-word stream between the collector and the move list / search logic.
// The collector drives the master side; the consumer drives move_ready.
interface square_move_if #(
   parameter int WORD_W = 32,
   parameter int IDX_W  = 4
);
   logic [WORD_W-1:0] move_out;
   logic              move_valid;
   logic              move_ready;
   logic [IDX_W-1:0]  move_idx;

   modport master (
      output move_out,
      output move_valid,
      output move_idx,
      input  move_ready
   );

   modport slave (
      input  move_out,
      input  move_valid,
      input  move_idx,
      output move_ready
   );
endinterface

// File: rtl/square_move_collector.sv
// Snapshots one square's 16 move words on start and streams them out one per beat.
// Define MOVE_COLLECTOR_ZERO_SKIP_EN to drop EMPTY_MOVE (all-zero) words from the stream.
module square_move_collector #(
   parameter int NUM_WORDS = 16,
   parameter int WORD_W    = 32,
   parameter int IDX_W     = 4,
   parameter int CNT_W     = 5
) (
   input  logic                        clk,
   input  logic                        clear_n,
   input  logic                        enable,
   input  logic                        start,
   input  logic [NUM_WORDS*WORD_W-1:0] moves_in,
   square_move_if.master               mv,
   output logic [CNT_W-1:0]            move_count,
   output logic                        busy,
   output logic                        done
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_SCAN = 2'd1;
   localparam logic [1:0] ST_WAIT = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   logic [1:0]        state_reg;
   logic [IDX_W-1:0]  idx_reg;
   logic [WORD_W-1:0] move_out_reg;
   logic              move_valid_reg;
   logic [IDX_W-1:0]  move_idx_reg;
   logic [CNT_W-1:0]  count_reg;
   logic [WORD_W-1:0] snap_reg [NUM_WORDS];
   logic [WORD_W-1:0] word_in  [NUM_WORDS];
   logic [WORD_W-1:0] cur_word;
   logic              emit;
   logic              last_idx;

   generate
      for (genvar gi = 0; gi < NUM_WORDS; gi++) begin : g_unpack
         assign word_in[gi] = moves_in[gi*WORD_W +: WORD_W];
      end
   endgenerate

   assign cur_word = snap_reg[idx_reg];
   assign last_idx = (idx_reg == IDX_W'(NUM_WORDS - 1));

`ifdef MOVE_COLLECTOR_ZERO_SKIP_EN
   assign emit = (cur_word != '0);
`else
   assign emit = 1'b1;
`endif

   // Snapshot is only loaded on an accepted start, so later moves_in changes are invisible.
   always_ff @(posedge clk) begin
      if (!clear_n) begin
         for (int i = 0; i < NUM_WORDS; i++) snap_reg[i] <= '0;
      end else if (enable && state_reg == ST_IDLE && start) begin
         for (int i = 0; i < NUM_WORDS; i++) snap_reg[i] <= word_in[i];
      end
   end

   always_ff @(posedge clk) begin
      if (!clear_n) begin
         state_reg      <= ST_IDLE;
         idx_reg        <= '0;
         move_out_reg   <= '0;
         move_valid_reg <= 1'b0;
         move_idx_reg   <= '0;
         count_reg      <= '0;
      end else if (enable) begin
         case (state_reg)
            ST_IDLE: begin
               if (start) begin
                  idx_reg   <= '0;
                  count_reg <= '0;
                  state_reg <= ST_SCAN;
               end
            end
            ST_SCAN: begin
               if (emit) begin
                  move_out_reg   <= cur_word;
                  move_idx_reg   <= idx_reg;
                  move_valid_reg <= 1'b1;
                  state_reg      <= ST_WAIT;
               end else if (last_idx) begin
                  state_reg <= ST_DONE;
               end else begin
                  idx_reg <= idx_reg + 1'b1;
               end
            end
            ST_WAIT: begin
               if (mv.move_ready) begin
                  move_valid_reg <= 1'b0;
                  count_reg      <= count_reg + 1'b1;
                  if (last_idx) begin
                     state_reg <= ST_DONE;
                  end else begin
                     idx_reg   <= idx_reg + 1'b1;
                     state_reg <= ST_SCAN;
                  end
               end
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

   assign mv.move_out   = move_out_reg;
   assign mv.move_valid = move_valid_reg;
   assign mv.move_idx   = move_idx_reg;
   assign move_count    = count_reg;
   assign busy          = (state_reg != ST_IDLE);
   assign done          = (state_reg == ST_DONE);

endmodule

// File: tb/tb_square_move_collector.sv
// Randomized scoreboard bench for square_move_collector; follows the build's
// MOVE_COLLECTOR_ZERO_SKIP_EN setting when predicting which words become beats.
module tb_square_move_collector;

   localparam int NUM_WORDS = 16;
   localparam int WORD_W    = 32;
   localparam int IDX_W     = 4;
   localparam int CNT_W     = 5;
`ifdef MOVE_COLLECTOR_ZERO_SKIP_EN
   localparam bit SKIP = 1'b1;
`else
   localparam bit SKIP = 1'b0;
`endif

   typedef struct packed {
      logic [WORD_W-1:0] word;
      logic [IDX_W-1:0]  idx;
   } beat_t;

   logic                        clk = 1'b0;
   logic                        clear_n;
   logic                        enable;
   logic                        start;
   logic [NUM_WORDS*WORD_W-1:0] moves_in;
   logic [CNT_W-1:0]            move_count;
   logic                        busy;
   logic                        done;

   square_move_if #(.WORD_W(WORD_W), .IDX_W(IDX_W)) mif ();

   square_move_collector #(
      .NUM_WORDS(NUM_WORDS), .WORD_W(WORD_W), .IDX_W(IDX_W), .CNT_W(CNT_W)
   ) dut (
      .clk        (clk),
      .clear_n    (clear_n),
      .enable     (enable),
      .start      (start),
      .moves_in   (moves_in),
      .mv         (mif.master),
      .move_count (move_count),
      .busy       (busy),
      .done       (done)
   );

   always #5 clk = ~clk;

   int          vectors = 0;
   int          miscompares = 0;
   bit          mon_en = 1'b0;
   int          ready_mode = 0;  // 0 always, 1 toggle, 2 random, 3 low, 4 low while idx 3 is offered
   logic [31:0] words [NUM_WORDS];
   beat_t       exp_q [$];
   int          done_q [$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Ready driver: updates just after each rising edge.
   initial begin
      mif.move_ready = 1'b0;
      forever begin
         @(posedge clk);
         #2;
         case (ready_mode)
            0:       mif.move_ready = 1'b1;
            1:       mif.move_ready = ~mif.move_ready;
            2:       mif.move_ready = 1'($urandom_range(0, 1));
            4:       mif.move_ready = !(mif.move_valid && mif.move_idx == 4'd3);
            default: mif.move_ready = 1'b0;
         endcase
      end
   end

   // Monitor: the head of exp_q must be on the bus whenever move_valid is high.
   always @(negedge clk) begin
      if (mon_en && clear_n) begin
         if (mif.move_valid) begin
            if (exp_q.size() == 0) begin
               check("unexpected_beat", {31'd0, mif.move_valid}, 32'd0);
            end else begin
               check("beat_word", mif.move_out, exp_q[0].word);
               check("beat_idx", {28'd0, mif.move_idx}, {28'd0, exp_q[0].idx});
               if (mif.move_ready && enable) begin
                  $display("beat idx=%0d word=0x%08h count=%0d", mif.move_idx, mif.move_out, move_count);
                  void'(exp_q.pop_front());
               end
            end
         end
         if (done && enable) begin
            if (done_q.size() == 0) begin
               check("unexpected_done", {31'd0, done}, 32'd0);
            end else begin
               check("done_count", {27'd0, move_count}, done_q.pop_front());
               check("beats_left", exp_q.size(), 32'd0);
            end
         end
      end
   end

   // Reference model: which words become beats, and the stream length with ready held high.
   function automatic int predict();
      int n = 0;
      for (int i = 0; i < NUM_WORDS; i++) begin
         if (!SKIP || words[i] != 32'd0) begin
            exp_q.push_back('{word: words[i], idx: 4'(i)});
            n++;
         end
      end
      done_q.push_back(n);
      return 1 + 2 * n + (NUM_WORDS - n);
   endfunction

   task automatic pulse_start();
      @(posedge clk); #1;
      enable = 1'b1;
      start  = 1'b1;
      for (int i = 0; i < NUM_WORDS; i++) moves_in[i*WORD_W +: WORD_W] = words[i];
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 0; i < NUM_WORDS; i++) moves_in[i*WORD_W +: WORD_W] = $urandom;
   endtask

   task automatic wait_done(input bit rand_en, output int cyc);
      bit seen = 1'b0;
      cyc = 0;
      for (int c = 1; c <= 600; c++) begin
         @(negedge clk);
         if (done && enable) begin
            seen = 1'b1;
            cyc  = c;
            break;
         end
         @(posedge clk); #1;
         if (rand_en) enable = ($urandom_range(0, 7) != 0);
      end
      enable = 1'b1;
      if (!seen) check("done_timeout", 32'd0, 32'd1);
      @(posedge clk); #1;
   endtask

   task automatic run_stream(input int rmode, input bit rand_en, input bit chk_time);
      int exp_cyc;
      int cyc;
      exp_cyc    = predict();
      ready_mode = rmode;
      pulse_start();
      wait_done(rand_en, cyc);
      if (chk_time) check("done_cycle", cyc, exp_cyc);
      ready_mode = 0;
   endtask

   initial begin
      int cyc;
      bit found;
      clear_n  = 1'b0;
      enable   = 1'b1;
      start    = 1'b0;
      moves_in = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_valid", {31'd0, mif.move_valid}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_count", {27'd0, move_count}, 32'd0);
      check("rst_out", mif.move_out, 32'd0);
      check("rst_idx", {28'd0, mif.move_idx}, 32'd0);
      @(posedge clk); #1;
      clear_n = 1'b1;
      mon_en  = 1'b1;

      // All words empty.
      for (int i = 0; i < NUM_WORDS; i++) words[i] = 32'd0;
      run_stream(0, 1'b0, 1'b1);

      // Two sparse moves.
      words[1] = 32'h0000_0514;
      words[9] = 32'h0000_00AB;
      run_stream(0, 1'b0, 1'b1);

      // Full square, ready toggling.
      for (int i = 0; i < NUM_WORDS; i++) words[i] = 32'h100 + i;
      run_stream(1, 1'b0, 1'b0);

      // Freeze while word 3 is held, plus a start pulse while busy.
      for (int i = 0; i < NUM_WORDS; i++) words[i] = 32'h200 + i;
      cyc = predict();
      ready_mode = 4;
      pulse_start();
      found = 1'b0;
      for (int c = 0; c < 100 && !found; c++) begin
         @(negedge clk);
         found = mif.move_valid && mif.move_idx == 4'd3;
      end
      check("freeze_reach_idx3", {31'd0, found}, 32'd1);
      @(posedge clk); #1;
      enable = 1'b0;
      ready_mode = 0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         check("freeze_valid", {31'd0, mif.move_valid}, 32'd1);
         check("freeze_idx", {28'd0, mif.move_idx}, 32'd3);
         @(posedge clk); #1;
      end
      enable = 1'b1;
      @(posedge clk); #1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done(1'b0, cyc);

      // Clear while a beat is held: beat dropped, no done.
      for (int i = 0; i < NUM_WORDS; i++) words[i] = 32'h300 + i;
      void'(predict());
      ready_mode = 3;
      pulse_start();
      repeat (4) @(posedge clk);
      #1;
      clear_n = 1'b0;
      @(posedge clk); #1;
      clear_n = 1'b1;
      exp_q.delete();
      done_q.delete();
      @(negedge clk);
      check("clr_valid", {31'd0, mif.move_valid}, 32'd0);
      check("clr_busy", {31'd0, busy}, 32'd0);
      check("clr_count", {27'd0, move_count}, 32'd0);
      repeat (30) @(posedge clk);
      #1;
      ready_mode = 0;

      // Only word 0 populated.
      for (int i = 0; i < NUM_WORDS; i++) words[i] = 32'd0;
      words[0] = 32'h1;
      run_stream(0, 1'b0, 1'b1);

      // Random squares with random ready and enable drops.
      for (int s = 0; s < 8; s++) begin
         for (int i = 0; i < NUM_WORDS; i++)
            words[i] = ($urandom_range(0, 9) < 4) ? 32'd0 : $urandom;
         if (s == 7) run_stream(0, 1'b0, 1'b1);
         else        run_stream(2, 1'b1, 1'b0);
      end

      repeat (3) @(posedge clk);
      check("final_queue", exp_q.size() + done_q.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
